// File: rtl/sort_pkg.sv
// Shared types and helpers for the 32x8 sorter frame sequencer.
// Frames move between a 32-entry byte array and the sorter's flat 256-bit bus.
package sort_pkg;

  localparam int unsigned N_ELEM = 32;
  localparam int unsigned DW     = 8;
  localparam int unsigned CW     = 6;  // holds 0..N_ELEM inclusive
  localparam int unsigned AW     = 5;  // addresses one of N_ELEM slots
  localparam logic [DW-1:0] PAD_VAL = 8'hFF;

  typedef logic [DW-1:0] elem_t;
  typedef elem_t frame_arr_t [N_ELEM];

  typedef enum logic [1:0] {
    FILL,
    LAUNCH,
    WAIT,
    DRAIN
  } state_t;

  // Element k lands at bits [8k+7:8k]
  function automatic logic [N_ELEM*DW-1:0] pack_frame(input frame_arr_t arr);
    logic [N_ELEM*DW-1:0] v;
    v = '0;
    for (int unsigned k = 0; k < N_ELEM; k++) begin
      v[k*DW +: DW] = arr[k];
    end
    return v;
  endfunction

  function automatic frame_arr_t unpack_frame(input logic [N_ELEM*DW-1:0] v);
    frame_arr_t arr;
    for (int unsigned k = 0; k < N_ELEM; k++) begin
      arr[k] = v[k*DW +: DW];
    end
    return arr;
  endfunction

endpackage

// File: rtl/sort_frame_buf.sv
// 32x8 frame register file: byte write, pad-from-index, bulk load from the
// sorter result bus and an indexed read port.
module sort_frame_buf
  import sort_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_wr_en,
  input  logic [CW-1:0]          i_wr_idx,
  input  logic [DW-1:0]          i_wr_data,
  input  logic                   i_pad_en,
  input  logic [CW-1:0]          i_pad_from,
  input  logic                   i_load_en,
  input  logic [N_ELEM*DW-1:0]   i_load_data,
  input  logic [CW-1:0]          i_rd_idx,
  output logic [DW-1:0]          o_rd_data,
  output logic [N_ELEM*DW-1:0]   o_frame
);

  frame_arr_t r_mem;
  frame_arr_t w_load;

  always_comb begin
    w_load = unpack_frame(i_load_data);
  end

  // Byte write and padding may coincide on the closing byte; the write wins
  // for its own slot and padding covers everything above it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < N_ELEM; k++) begin
        r_mem[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < N_ELEM; k++) begin
        if (i_load_en) begin
          r_mem[k] <= w_load[k];
        end else if (i_wr_en && (i_wr_idx == CW'(k))) begin
          r_mem[k] <= i_wr_data;
        end else if (i_pad_en && (CW'(k) >= i_pad_from)) begin
          r_mem[k] <= PAD_VAL;
        end
      end
    end
  end

  assign o_rd_data = (i_rd_idx < CW'(N_ELEM)) ? r_mem[i_rd_idx[AW-1:0]] : PAD_VAL;
  assign o_frame   = pack_frame(r_mem);

endmodule

// File: rtl/sort_frame_ctrl.sv
// Byte-stream sequencer around an external 32-element 3-cycle sorter:
// collects a frame, launches the sorter, captures the result and drains it.
module sort_frame_ctrl
  import sort_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
)
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DW-1:0]         s_data,
  input  logic                  s_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DW-1:0]         m_data,
  output logic                  m_last,
  output logic                  srt_vld_in,
  output logic [N_ELEM*DW-1:0]  srt_din,
  input  logic                  srt_vld_out,
  input  logic [N_ELEM*DW-1:0]  srt_dout,
  output logic                  busy,
  output logic                  err
);

  localparam int unsigned WCW = $clog2(TIMEOUT + 1);

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   r_idx;
  logic [WCW-1:0]  r_wcnt;
  logic            r_srt_vld_in;
  logic            r_m_valid;
  logic            r_m_last;
  logic [DW-1:0]   r_m_data;
  logic            r_err;

  logic            w_accept;
  logic            w_close;
  logic            w_capture;
  logic            w_timeout;
  logic [CW-1:0]   w_cnt_inc;
  logic [CW-1:0]   w_cnt_dec;
  logic [CW-1:0]   w_idx_inc;
  logic [DW-1:0]   w_rd_data;
  logic [N_ELEM*DW-1:0] w_frame;

  assign w_accept  = (r_state == FILL) && s_valid;
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_cnt_dec = r_cnt - 1'b1;
  assign w_idx_inc = r_idx + 1'b1;
  assign w_close   = w_accept && (s_last || (w_cnt_inc == CW'(N_ELEM)));
  assign w_capture = (r_state == WAIT) && srt_vld_out;
  assign w_timeout = (r_state == WAIT) && !srt_vld_out && (r_wcnt == WCW'(TIMEOUT - 1));

  // The read port looks one slot ahead so m_data can be registered on handshake
  sort_frame_buf u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_wr_en     (w_accept),
    .i_wr_idx    (r_cnt),
    .i_wr_data   (s_data),
    .i_pad_en    (w_close),
    .i_pad_from  (w_cnt_inc),
    .i_load_en   (w_capture),
    .i_load_data (srt_dout),
    .i_rd_idx    (w_idx_inc),
    .o_rd_data   (w_rd_data),
    .o_frame     (w_frame)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= FILL;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_wcnt       <= '0;
      r_srt_vld_in <= 1'b0;
      r_m_valid    <= 1'b0;
      r_m_last     <= 1'b0;
      r_m_data     <= '0;
      r_err        <= 1'b0;
    end else begin
      r_srt_vld_in <= 1'b0;
      r_err        <= 1'b0;
      unique case (r_state)
        FILL: begin
          if (w_accept) begin
            r_cnt <= w_cnt_inc;
            if (w_close) begin
              r_srt_vld_in <= 1'b1;
              r_state      <= LAUNCH;
            end
          end
        end
        LAUNCH: begin
          r_wcnt  <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          if (w_capture) begin
            r_idx     <= '0;
            r_m_valid <= 1'b1;
            r_m_data  <= srt_dout[DW-1:0];
            r_m_last  <= (r_cnt == CW'(1));
            r_state   <= DRAIN;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_cnt   <= '0;
            r_state <= FILL;
          end else begin
            r_wcnt <= r_wcnt + 1'b1;
          end
        end
        DRAIN: begin
          if (m_ready) begin
            if (r_m_last) begin
              r_m_valid <= 1'b0;
              r_m_last  <= 1'b0;
              r_cnt     <= '0;
              r_idx     <= '0;
              r_state   <= FILL;
            end else begin
              r_idx    <= w_idx_inc;
              r_m_data <= w_rd_data;
              r_m_last <= (w_idx_inc == w_cnt_dec);
            end
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

  assign s_ready    = (r_state == FILL);
  assign busy       = (r_state != FILL);
  assign m_valid    = r_m_valid;
  assign m_data     = r_m_data;
  assign m_last     = r_m_last;
  assign srt_vld_in = r_srt_vld_in;
  assign srt_din    = w_frame;
  assign err        = r_err;

endmodule

// File: tb/tb_sort_frame_ctrl.sv
// Bench for sort_frame_ctrl: behavioural sorter stub, queue-based output model
// checked every cycle, plus directed timing/boundary checks.
module tb_sort_frame_ctrl;

  localparam int unsigned TO = 15;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         s_valid = 1'b0;
  logic         s_last = 1'b0;
  logic [7:0]   s_data = 8'h00;
  logic         m_ready = 1'b0;
  logic         spur = 1'b0;
  logic         stub_en = 1'b1;
  logic         s_ready, m_valid, m_last, srt_vld_in, srt_vld_out, busy, err;
  logic [7:0]   m_data;
  logic [255:0] srt_din, srt_dout;

  int checks = 0;
  int failures = 0;
  bit [7:0] exp_stream[$];
  bit       exp_last[$];
  int       exp_rd = 0;

  logic         pv0 = 1'b0, pv1 = 1'b0, pv2 = 1'b0;
  logic [255:0] pd0 = '0, pd1 = '0, pd2 = '0;

  always #5 clk = ~clk;

  sort_frame_ctrl #(.TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .s_last      (s_last),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_last      (m_last),
    .srt_vld_in  (srt_vld_in),
    .srt_din     (srt_din),
    .srt_vld_out (srt_vld_out),
    .srt_dout    (srt_dout),
    .busy        (busy),
    .err         (err)
  );

  function automatic logic [255:0] sort_vec(input logic [255:0] v);
    bit [7:0] q[$];
    logic [255:0] r;
    for (int i = 0; i < 32; i++) q.push_back(v[i*8 +: 8]);
    q.sort();
    r = '0;
    for (int i = 0; i < 32; i++) r[i*8 +: 8] = q[i];
    return r;
  endfunction

  // Sorter stand-in: launch sampled at edge E, result sampled by the DUT at E+3
  always @(posedge clk) begin
    pv0 <= srt_vld_in && stub_en;
    pd0 <= sort_vec(srt_din);
    pv1 <= pv0;
    pd1 <= pd0;
    pv2 <= pv1;
    pd2 <= pd1;
  end
  assign srt_vld_out = pv2 | spur;
  assign srt_dout    = spur ? {32{8'h5A}} : pd2;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  task automatic push_model(input bit [7:0] bytes[$]);
    bit [7:0] q[$];
    q = bytes;
    q.sort();
    foreach (q[i]) begin
      exp_stream.push_back(q[i]);
      exp_last.push_back(i == q.size() - 1);
    end
  endtask

  // Called at posedge+1 with the DUT in FILL; returns at posedge+1 after the closing edge
  task automatic send_frame(input bit [7:0] bytes[$], input int spur_at);
    for (int i = 0; i < bytes.size(); i++) begin
      s_valid = 1'b1;
      s_data  = bytes[i];
      s_last  = (i == bytes.size() - 1) && (bytes.size() < 32);
      spur    = (i == spur_at);
      chk("s_ready_fill", s_ready, 1);
      @(posedge clk); #1;
      if (spur) begin
        spur = 1'b0;
        chk("busy_after_spurious", busy, 0);
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input bit toggle);
    int n = 0;
    while (exp_rd < exp_stream.size() && n < budget) begin
      @(posedge clk); #1;
      if (toggle) m_ready = ~m_ready;
      n++;
    end
    chk("drain_complete", exp_rd, exp_stream.size());
    chk("s_ready_after_last", s_ready, 1);
    chk("m_valid_after_last", m_valid, 0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_last"}, m_last, 0);
    chk({tag, "_m_data"}, m_data, 0);
    chk({tag, "_srt_vld_in"}, srt_vld_in, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_s_ready"}, s_ready, 1);
    chk({tag, "_srt_din"}, srt_din, 0);
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_rd = exp_stream.size();
      end else if (m_valid) begin
        chk("no_extra_byte", (exp_rd < exp_stream.size()), 1);
        if (exp_rd < exp_stream.size()) begin
          chk("m_data", m_data, exp_stream[exp_rd]);
          chk("m_last", m_last, exp_last[exp_rd]);
        end
        chk("s_ready_while_draining", s_ready, 0);
        if (m_ready) exp_rd++;
      end
    end
  endtask

  task automatic main_seq();
    bit [7:0] f[$];
    logic [255:0] ev;
    int n;

    #2 rst_n = 1'b0;
    #1 check_reset_values("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Full frame 31..0, sink always ready: exact launch/capture timing
    f.delete();
    for (int i = 0; i < 32; i++) f.push_back(8'(31 - i));
    for (int i = 0; i < 32; i++) begin
      exp_stream.push_back(8'(i));
      exp_last.push_back(i == 31);
    end
    m_ready = 1'b1;
    send_frame(f, -1);
    chk("t1_launch_pulse", srt_vld_in, 1);
    chk("t1_busy", busy, 1);
    chk("t1_s_ready_low", s_ready, 0);
    @(posedge clk); #1;
    chk("t1_launch_single", srt_vld_in, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t1_m_valid_early", m_valid, 0);
    @(posedge clk); #1;
    chk("t1_m_valid_t5", m_valid, 1);
    chk("t1_first_byte", m_data, 8'd0);
    wait_drain(100, 1'b0);

    // Short frame with a real 0xFF among the data
    f.delete();
    f.push_back(8'd9); f.push_back(8'd3); f.push_back(8'hFF);
    f.push_back(8'd3); f.push_back(8'd1);
    exp_stream.push_back(8'd1);  exp_last.push_back(1'b0);
    exp_stream.push_back(8'd3);  exp_last.push_back(1'b0);
    exp_stream.push_back(8'd3);  exp_last.push_back(1'b0);
    exp_stream.push_back(8'd9);  exp_last.push_back(1'b0);
    exp_stream.push_back(8'hFF); exp_last.push_back(1'b1);
    ev = {32{8'hFF}};
    for (int i = 0; i < 5; i++) ev[i*8 +: 8] = f[i];
    send_frame(f, -1);
    chk("t2_srt_din_padded", srt_din, ev);
    wait_drain(100, 1'b0);

    // Random frame with duplicates, sink stalls every other cycle
    f.delete();
    for (int i = 0; i < 32; i++) f.push_back((i % 7 == 0) ? 8'hFF : 8'($urandom_range(0, 40)));
    push_model(f);
    m_ready = 1'b0;
    send_frame(f, -1);
    wait_drain(300, 1'b1);

    // Sorter never answers: one err pulse TO cycles after the launch edge
    stub_en = 1'b0;
    m_ready = 1'b1;
    f.delete();
    for (int i = 0; i < 4; i++) f.push_back(8'(10 + i));
    send_frame(f, -1);
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      chk("t4_err", err, (k == int'(TO) + 1));
      if (k == int'(TO) + 1) chk("t4_back_to_fill", s_ready, 1);
    end
    stub_en = 1'b1;
    f.delete();
    for (int i = 0; i < 7; i++) f.push_back(8'($urandom_range(0, 255)));
    push_model(f);
    send_frame(f, -1);
    wait_drain(100, 1'b0);

    // Reset while draining at idx 10
    f.delete();
    for (int i = 0; i < 32; i++) f.push_back(8'($urandom_range(0, 255)));
    push_model(f);
    send_frame(f, -1);
    n = 0;
    while (!m_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t5_m_valid_seen", m_valid, 1);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_values("t5_reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    f.delete();
    for (int i = 0; i < 32; i++) f.push_back(8'($urandom_range(0, 255)));
    push_model(f);
    send_frame(f, -1);
    wait_drain(100, 1'b0);

    // Spurious sorter result during FILL must not disturb the frame
    f.delete();
    for (int i = 0; i < 10; i++) f.push_back(8'($urandom_range(0, 200)));
    push_model(f);
    send_frame(f, 4);
    wait_drain(100, 1'b0);

    // Single-byte frame
    f.delete();
    f.push_back(8'h42);
    exp_stream.push_back(8'h42);
    exp_last.push_back(1'b1);
    send_frame(f, -1);
    wait_drain(100, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    fork
      compare_loop();
      main_seq();
    join_any
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sort_frame_ctrl.md
# sort_frame_ctrl

Sequencer that feeds the 32-element unsigned 8-bit parallel sorter from a byte stream and returns the sorted frame as a byte stream. Collects up to 32 bytes through a valid/ready input port, fires the sorter with a single-cycle launch pulse, captures its 3-cycle-latency result and drains it smallest-first through a valid/ready output port. Sits between the upstream byte source and downstream consumer; the sorter instance stays outside this block.

## Interface
- N_ELEM, 32: elements per frame (sorter width); fixed to the sorter.
- TIMEOUT, 15: max cycles in WAIT before abort.
- clk  input  1  system clock, all logic rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- s_valid  input  1  input byte valid.
- s_ready  output  1  block accepts input byte.
- s_data  input  8  input byte.
- s_last  input  1  marks final byte of a short frame (<32 bytes).
- m_valid  output  1  output byte valid.
- m_ready  input  1  downstream accepts output byte.
- m_data  output  8  sorted byte, ascending.
- m_last  output  1  last byte of sorted frame.
- srt_vld_in  output  1  sorter launch pulse.
- srt_din  output  256  frame to sorter, element k at bits [8k+7:8k].
- srt_vld_out  input  1  sorter result valid.
- srt_dout  input  256  sorted frame, element 0 (bits [7:0]) smallest.
- busy  output  1  high in any state other than FILL.
- err  output  1  one-cycle pulse on sorter timeout.

## Operation
- States: FILL, LAUNCH, WAIT, DRAIN. Reset state FILL.
- FILL: s_ready=1. Each s_valid&&s_ready writes s_data to buf[cnt], cnt++. Frame closes when cnt reaches 32 or accepted byte carries s_last; then -> LAUNCH. Slots cnt..31 are forced to 8'hFF (pad) on close.
- LAUNCH: srt_vld_in=1 for exactly one cycle, srt_din=buf; -> WAIT; wait counter cleared.
- WAIT: srt_vld_in=0. On srt_vld_out: buf <= srt_dout, idx<=0, -> DRAIN. Counter increments each cycle; reaching TIMEOUT without srt_vld_out: err pulse, cnt<=0, -> FILL (frame discarded).
- DRAIN: m_valid=1, m_data=buf[idx], m_last=(idx==cnt-1). On m_ready: idx++; on handshake with m_last: cnt<=0, -> FILL. m_data/m_last hold stable while m_valid&&!m_ready.
- Pads (0xFF) sort to the tail; only first cnt elements are emitted, correct even when real data contains 0xFF (identical values).
- srt_vld_out outside WAIT ignored. s_last on first byte gives cnt=1, valid frame. Zero-length frames impossible.
- cnt, idx: 6 bits, range 0..32. Wait counter: clog2(TIMEOUT+1) bits.
- srt_din driven from buf at all times; sorter samples only under srt_vld_in.

## Timing
- Reset (async assert): state FILL, cnt=0, idx=0, buf all 0, srt_vld_in=0, m_valid=0, m_last=0, m_data=0, err=0, busy=0; s_ready=1 (decoded from FILL). Reset mid-frame discards all data, no output.
- Closing byte accepted at edge t -> LAUNCH cycle t+1 (srt_vld_in high) -> sorter result at t+4 -> captured at that edge -> m_valid high cycle t+5 with smallest byte.
- Full frame with m_ready held high: 32 accept cycles + 4 + 32 drain cycles; s_ready first returns high the cycle after final m_last handshake.
- No overlap: s_ready=0 from LAUNCH through DRAIN (single buffer).
- All outputs registered or decoded from state register; no combinational path from s_valid/m_ready to s_ready/m_valid.

## Structure
- Shared package sort_pkg: N_ELEM=32, DW=8, PAD_VAL=8'hFF, state enum (FILL, LAUNCH, WAIT, DRAIN), pack/unpack functions between 32x8 array and 256-bit vector.
- One sub-module: sort_frame_buf, 32x8 register file with indexed write, pad-from-index, bulk load from 256-bit, indexed read.

## Test plan
- 32 bytes 31..0 then m_ready=1: srt_vld_in one pulse at t+1, m_valid at t+5, output 0..31, m_last on 31.
- 5 bytes {9,3,0xFF,3,1} with s_last: srt_din slots 5..31 = 0xFF; output 1,3,3,9,0xFF, m_last on 5th, exactly 5 bytes.
- m_ready toggled 1/0 during drain of random frame: m_data stable while stalled, no byte lost or duplicated, s_ready 0 until last handshake.
- srt_vld_out never asserted: err pulses once exactly TIMEOUT cycles after LAUNCH, back to FILL, no m_valid; next frame sorts correctly.
- rst_n asserted in DRAIN at idx=10: all outputs to reset values immediately; after release, new 32-byte frame sorts correctly.
- Spurious srt_vld_out during FILL: ignored, cnt and buffer unchanged.
